ysyx_22040386_wb_stage: RTL
===========================

YSYX_22040386_WB_STAGE -- requirements
Module: ysyx_22040386_wb_stage

Interface
REQ-001 SHALL have parameter XLEN, default 64, register/CSR data width.
REQ-002 SHALL have parameter AW, default 5, register address width.
REQ-003 SHALL have one clock and an asynchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, asynchronous active-high reset.
REQ-004 SHALL have port i_valid input 1: upstream (MEM) instruction valid.
REQ-005 SHALL have port o_ready input-side output 1: stage can accept; equals ~i_stall.
REQ-006 SHALL have port i_stall input 1: hold the current stage contents.
REQ-007 SHALL have port i_flush input 1: kill the incoming instruction.
REQ-008 SHALL have port i_reg_wr_data input XLEN: ALU/load result.
REQ-009 SHALL have port i_RegWrite input 1: GPR write request.
REQ-010 SHALL have port i_reg_wr_addr input AW: destination GPR.
REQ-011 SHALL have port i_csr_reg_write input 1: CSR-read result goes to the GPR.
REQ-012 SHALL have port i_csr_r_data input XLEN: CSR read data.
REQ-013 SHALL have ports for the register-file write port: o_reg_wr_data output XLEN; o_RegWrite output 1; o_reg_wr_addr output AW.
REQ-014 SHALL have port o_retire output 1: one-cycle pulse per retired instruction.
REQ-015 SHALL have port o_instret output 64: retired-instruction count.

Function
REQ-016 SHALL capture on a clk edge when i_valid & o_ready & ~i_flush; the captured entry's valid bit is set; latency is 1 cycle from input to register-file write.
REQ-017 SHALL clear the entry's valid bit on a clk edge when o_ready & (~i_valid | i_flush).
REQ-018 SHALL hold the entry unchanged while i_stall=1, regardless of i_valid/i_flush.
REQ-019 SHALL select the captured data as i_csr_r_data when i_csr_reg_write=1, else i_reg_wr_data.
REQ-020 SHALL capture the write-enable as (i_RegWrite | i_csr_reg_write) & (i_reg_wr_addr != 0); writes to x0 are suppressed.
REQ-021 SHALL assert o_RegWrite only in the first cycle an entry is valid; a held (stalled) entry SHALL NOT write again (a written flag is set after the first cycle and cleared on a new capture).
REQ-022 SHALL drive o_reg_wr_data/o_reg_wr_addr from the entry at all times.
REQ-023 SHALL pulse o_retire=1 for exactly one cycle per valid entry, in the same cycle as its o_RegWrite slot, including entries with no GPR write.
REQ-024 SHALL increment o_instret by 1 on each o_retire, wrapping from 2^64-1 to 0.
REQ-025 SHALL discard an instruction presented with i_flush=1: it does not retire.

Reset
REQ-026 SHALL, on rst=1, asynchronously clear: entry valid=0, written flag=0, o_RegWrite=0, o_retire=0, o_reg_wr_data=0, o_reg_wr_addr=0, o_instret=0.
REQ-027 SHALL abort an in-flight or stalled entry when rst is asserted mid-operation: it neither writes nor retires after reset is released.

Configuration
REQ-028 SHALL, with YSYX_22040386_WB_FWD_EN defined, add the following outputs: o_fwd_valid 1 = entry valid & write-enable (independent of the written flag); o_fwd_addr AW; o_fwd_data XLEN. These are combinational from the entry, for EX-stage bypass.
REQ-029 SHALL, without YSYX_22040386_WB_FWD_EN, omit those ports, with all other behaviour identical.

Verification
REQ-030 SHALL cover: i_valid=1, i_RegWrite=1, addr=5, data=0x1234 -> next cycle o_RegWrite=1, addr=5, data=0x1234, o_retire=1, o_instret=1.
REQ-031 SHALL cover: i_csr_reg_write=1, csr_r_data=0xDEAD, reg_wr_data=0xBEEF, addr=3 -> o_reg_wr_data=0xDEAD, o_RegWrite=1.
REQ-032 SHALL cover: i_RegWrite=1, addr=0 -> o_RegWrite=0, o_retire=1.
REQ-033 SHALL cover: capture then i_stall=1 for 3 cycles -> o_RegWrite high 1 cycle only, o_retire 1 pulse, o_instret +1; o_ready=0 during stall.
REQ-034 SHALL cover: i_valid=1 with i_flush=1 -> no write, no retire, o_instret unchanged; and force o_instret=2^64-1 then retire -> 0.
REQ-035 SHALL cover: assert rst during a stalled valid entry -> all outputs 0 immediately; no write after release; with FWD_EN, o_fwd_valid=0.

Source files
------------

// File: rtl/ysyx_22040386_wb_stage_if.sv
// Bus bundle between the MEM stage and the write-back stage.
// Forwarding signals exist only when YSYX_22040386_WB_FWD_EN is defined.
interface ysyx_22040386_wb_stage_if #(
  parameter int XLEN = 64,
  parameter int AW   = 5
);
  // Upstream (MEM) side
  logic            i_valid;
  logic            o_ready;
  logic            i_stall;
  logic            i_flush;
  logic [XLEN-1:0] i_reg_wr_data;
  logic            i_RegWrite;
  logic [AW-1:0]   i_reg_wr_addr;
  logic            i_csr_reg_write;
  logic [XLEN-1:0] i_csr_r_data;

  // Register-file write port and retirement
  logic [XLEN-1:0] o_reg_wr_data;
  logic            o_RegWrite;
  logic [AW-1:0]   o_reg_wr_addr;
  logic            o_retire;
  logic [63:0]     o_instret;

`ifdef YSYX_22040386_WB_FWD_EN
  logic            o_fwd_valid;
  logic [AW-1:0]   o_fwd_addr;
  logic [XLEN-1:0] o_fwd_data;
`endif

  modport master (
    output i_valid, i_stall, i_flush, i_reg_wr_data, i_RegWrite,
           i_reg_wr_addr, i_csr_reg_write, i_csr_r_data,
    input  o_ready, o_reg_wr_data, o_RegWrite, o_reg_wr_addr, o_retire,
           o_instret
`ifdef YSYX_22040386_WB_FWD_EN
    , input o_fwd_valid, o_fwd_addr, o_fwd_data
`endif
  );

  modport slave (
    input  i_valid, i_stall, i_flush, i_reg_wr_data, i_RegWrite,
           i_reg_wr_addr, i_csr_reg_write, i_csr_r_data,
    output o_ready, o_reg_wr_data, o_RegWrite, o_reg_wr_addr, o_retire,
           o_instret
`ifdef YSYX_22040386_WB_FWD_EN
    , output o_fwd_valid, o_fwd_addr, o_fwd_data
`endif
  );
endinterface

// File: rtl/ysyx_22040386_wb_stage.sv
// Write-back stage: one-entry register, single-shot GPR write, retire pulse, instret.
// Define YSYX_22040386_WB_FWD_EN to expose the entry as an EX-stage bypass source.
module ysyx_22040386_wb_stage #(
  parameter int XLEN = 64,
  parameter int AW   = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  ysyx_22040386_wb_stage_if.slave  bus
);

  typedef struct packed {
    logic            valid;
    logic            written;
    logic            we;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } entry_t;

  entry_t      entry_q, entry_d;
  logic [63:0] instret_q, instret_d;
  logic        ready;
  logic        retire;

  assign ready  = ~bus.i_stall;
  // An entry retires exactly once: in its first valid cycle, before written is set.
  assign retire = entry_q.valid & ~entry_q.written;

  always_comb begin
    // NOTE: default every comb output up front so no path infers a latch.
    entry_d   = entry_q;
    instret_d = instret_q + 64'(retire);
    if (!ready) begin
      entry_d.written = entry_q.written | entry_q.valid;
    end else if (bus.i_valid && !bus.i_flush) begin
      entry_d.valid   = 1'b1;
      entry_d.written = 1'b0;
      entry_d.we      = (bus.i_RegWrite | bus.i_csr_reg_write) &
                        (bus.i_reg_wr_addr != '0);
      entry_d.addr    = bus.i_reg_wr_addr;
      entry_d.data    = bus.i_csr_reg_write ? bus.i_csr_r_data : bus.i_reg_wr_data;
    end else begin
      // Data/address stay visible; only the entry's liveness is dropped.
      entry_d.valid   = 1'b0;
      entry_d.written = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_q   <= '0;
      instret_q <= '0;
    end else begin
      entry_q   <= entry_d;
      instret_q <= instret_d;
    end
  end

  assign bus.o_ready       = ready;
  assign bus.o_reg_wr_data = entry_q.data;
  assign bus.o_reg_wr_addr = entry_q.addr;
  assign bus.o_RegWrite    = retire & entry_q.we;
  assign bus.o_retire      = retire;
  assign bus.o_instret     = instret_q;

`ifdef YSYX_22040386_WB_FWD_EN
  // Bypass stays valid for the whole life of the entry, even after its write slot.
  assign bus.o_fwd_valid = entry_q.valid & entry_q.we;
  assign bus.o_fwd_addr  = entry_q.addr;
  assign bus.o_fwd_data  = entry_q.data;
`endif

endmodule
